// File: rtl/gauss_blur3x3_pkg.sv
// Shared constants, FSM encoding and the per-channel 3x3 Gaussian kernel
// used by the gauss_blur3x3 filter.
package gauss_blur3x3_pkg;

  localparam int PIX_W      = 24;
  localparam int CH_W       = 8;
  localparam int NUM_CH     = 3;
  localparam int SUM_W      = 12;
  localparam int DEF_WIDTH  = 30;
  localparam int DEF_HEIGHT = 30;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // pix[2] = R, pix[1] = G, pix[0] = B
  typedef logic [NUM_CH-1:0][CH_W-1:0] pix_t;

  // taps are row-major, taps[4] is the centre; weights 1-2-1 / 2-4-2 / 1-2-1.
  // Max sum 16*255+8 = 4088 still fits SUM_W, so the result never exceeds 255.
  function automatic logic [CH_W-1:0] blur_ch(input logic [8:0][CH_W-1:0] taps);
    logic [SUM_W-1:0] s;
    s = SUM_W'(taps[0]) + SUM_W'(taps[2]) + SUM_W'(taps[6]) + SUM_W'(taps[8])
      + ((SUM_W'(taps[1]) + SUM_W'(taps[3]) + SUM_W'(taps[5]) + SUM_W'(taps[7])) << 1)
      + (SUM_W'(taps[4]) << 2)
      + SUM_W'(8);
    return s[SUM_W-1:4];
  endfunction

endpackage

// File: rtl/gauss_blur3x3_line_buffer.sv
// One-row delay line: dout is the pixel written DEPTH enabled shifts ago.
// Ring buffer with a single pointer; contents are never reset.
module gauss_blur3x3_line_buffer
  import gauss_blur3x3_pkg::*;
#(
  parameter int DEPTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PIX_W-1:0] mem [DEPTH];
  logic [PW-1:0]    ptr;

  assign dout = mem[ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     ptr <= '0;
    else if (en) ptr <= (ptr == PW'(DEPTH-1)) ? '0 : ptr + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (en) mem[ptr] <= din;
  end

endmodule

// File: rtl/gauss_blur3x3.sv
// Streaming 3x3 Gaussian blur over a WIDTH x HEIGHT RGB frame in raster order.
// Border pixels pass through unfiltered; output k follows input k+WIDTH+1.
module gauss_blur3x3
  import gauss_blur3x3_pkg::*;
#(
  parameter  int WIDTH  = DEF_WIDTH,
  parameter  int HEIGHT = DEF_HEIGHT,
  localparam int N      = WIDTH * HEIGHT,
  localparam int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [PIX_W-1:0]  pexil_in,
  output logic [PIX_W-1:0]  pexil_out,
  output logic              out_valid,
  output logic [ADDR_W-1:0] write_adrr,
  output logic              done
);

  localparam int CNT_W = $clog2(N + WIDTH + 2);
  localparam int COL_W = $clog2(WIDTH + 1);
  localparam int ROW_W = $clog2(HEIGHT + 1);

  logic [1:0]        state;
  logic [CNT_W-1:0]  in_cnt;
  logic [ADDR_W-1:0] out_cnt;
  logic [COL_W-1:0]  out_col;
  logic [ROW_W-1:0]  out_row;
  logic              out_pend;

  pix_t win [3][3];
  pix_t pix_new, lb1_q, lb2_q, blur_pix, next_pix;
  logic shift_en, shift_vld, is_border;

  // Flush drains the pipeline by shifting zeros for the last WIDTH+1 slots.
  assign shift_en = start && (((state == ST_RUN) && in_valid) ||
                    ((state == ST_FLUSH) && (in_cnt < CNT_W'(N + WIDTH + 1))));
  assign shift_vld = shift_en && (in_cnt >= CNT_W'(WIDTH + 1));
  assign pix_new   = (state == ST_RUN) ? pix_t'(pexil_in) : '0;

  gauss_blur3x3_line_buffer #(.DEPTH(WIDTH)) u_lb_row1 (
    .clk  (clk),
    .rst  (rst),
    .en   (shift_en),
    .din  (pix_new),
    .dout (lb1_q)
  );

  gauss_blur3x3_line_buffer #(.DEPTH(WIDTH)) u_lb_row2 (
    .clk  (clk),
    .rst  (rst),
    .en   (shift_en),
    .din  (lb1_q),
    .dout (lb2_q)
  );

  // Row 0 is the oldest line, column 2 the newest pixel; win[1][1] is the centre.
  always_ff @(posedge clk) begin
    if (shift_en) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lb2_q;
      win[1][2] <= lb1_q;
      win[2][2] <= pix_new;
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [8:0][CH_W-1:0] taps;
    for (genvar r = 0; r < 3; r++) begin : g_r
      for (genvar c = 0; c < 3; c++) begin : g_c
        assign taps[r*3+c] = win[r][c][ch];
      end
    end
    assign blur_pix[ch] = blur_ch(taps);
  end

  // Border outputs never look at neighbours, so stale line-buffer data is masked.
  assign is_border = (out_row == '0) || (out_row == ROW_W'(HEIGHT - 1)) ||
                     (out_col == '0) || (out_col == COL_W'(WIDTH - 1));
  assign next_pix  = is_border ? win[1][1] : blur_pix;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      in_cnt     <= '0;
      out_cnt    <= '0;
      out_col    <= '0;
      out_row    <= '0;
      out_pend   <= 1'b0;
      pexil_out  <= '0;
      out_valid  <= 1'b0;
      write_adrr <= '0;
      done       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_pend  <= shift_vld;
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state    <= ST_RUN;
            in_cnt   <= '0;
            out_cnt  <= '0;
            out_col  <= '0;
            out_row  <= '0;
            out_pend <= 1'b0;
          end
        end
        ST_RUN, ST_FLUSH: begin
          if (!start) begin
            state    <= ST_IDLE;
            in_cnt   <= '0;
            out_cnt  <= '0;
            out_col  <= '0;
            out_row  <= '0;
            out_pend <= 1'b0;
          end else begin
            if (shift_en) in_cnt <= in_cnt + CNT_W'(1);
            if ((state == ST_RUN) && shift_en && (in_cnt == CNT_W'(N - 1)))
              state <= ST_FLUSH;
            if (out_pend) begin
              pexil_out  <= next_pix;
              write_adrr <= out_cnt;
              out_valid  <= 1'b1;
              out_cnt    <= out_cnt + ADDR_W'(1);
              if (out_col == COL_W'(WIDTH - 1)) begin
                out_col <= '0;
                out_row <= out_row + ROW_W'(1);
              end else begin
                out_col <= out_col + COL_W'(1);
              end
              if (out_cnt == ADDR_W'(N - 1)) begin
                state <= ST_DONE;
                done  <= 1'b1;
              end
            end
          end
        end
        default: begin
          if (!start) begin
            state <= ST_IDLE;
            done  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gauss_blur3x3.sv
// Directed bench for gauss_blur3x3: constant, impulse, ramp, gapped and
// reset-interrupted frames checked against hand values and a convolution model.
module tb_gauss_blur3x3;

  localparam int W  = 30;
  localparam int H  = 30;
  localparam int N  = W * H;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [23:0]   pexil_in = '0;
  logic [23:0]   pexil_out;
  logic          out_valid;
  logic [AW-1:0] write_adrr;
  logic          done;

  gauss_blur3x3 dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .pexil_in   (pexil_in),
    .pexil_out  (pexil_out),
    .out_valid  (out_valid),
    .write_adrr (write_adrr),
    .done       (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  logic [23:0] frame   [N];
  logic [23:0] got_pix [N];
  logic [23:0] ref_pix [N];
  int          got_cyc [N];
  int          drv_cyc [N];
  int          got_n, adr_bad, done_cyc;

  // Advance to the next falling edge and record whatever the DUT emitted.
  task automatic tick();
    @(negedge clk);
    if (out_valid) begin
      if (got_n < N && int'(write_adrr) == got_n) begin
        got_pix[got_n] = pexil_out;
        got_cyc[got_n] = cyc;
      end else begin
        adr_bad++;
      end
      got_n++;
    end
    if (done && done_cyc < 0) done_cyc = cyc;
  endtask

  function automatic logic [23:0] gold(input int k);
    int r, c, s;
    logic [23:0] res;
    r = k / W;
    c = k % W;
    if (r == 0 || r == H-1 || c == 0 || c == W-1) return frame[k];
    res = '0;
    for (int ch = 0; ch < 3; ch++) begin
      s = 0;
      for (int dr = -1; dr <= 1; dr++)
        for (int dc = -1; dc <= 1; dc++)
          s += ((dr == 0) ? 2 : 1) * ((dc == 0) ? 2 : 1) * int'(frame[k + dr*W + dc][ch*8 +: 8]);
      res[ch*8 +: 8] = 8'((s + 8) >> 4);
    end
    return res;
  endfunction

  task automatic run_frame(input bit gaps, input int stop_at);
    got_n = 0; adr_bad = 0; done_cyc = -1;
    start = 1'b1; in_valid = 1'b0;
    tick(); tick();
    for (int i = 0; i < stop_at; i++) begin
      while (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0; pexil_in = 24'($urandom); tick();
      end
      in_valid = 1'b1; pexil_in = frame[i]; drv_cyc[i] = cyc; tick();
    end
    in_valid = 1'b0;
    if (stop_at == N)
      for (int t = 0; t < 100 && done_cyc < 0; t++) tick();
  endtask

  task automatic stop_frame();
    start = 1'b0;
    tick(); tick();
  endtask

  task automatic check_count(input string name);
    vectors++;
    if (got_n != N || adr_bad != 0) begin
      miscompares++;
      $display("FAIL %s_count: got %0d outputs (%0d out of order) want %0d in order", name, got_n, adr_bad, N);
    end
    vectors++;
    if (done_cyc < 0) begin
      miscompares++;
      $display("FAIL %s_done_timeout: done never rose, want rise within 100 cycles", name);
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || done !== 1'b0 || write_adrr !== '0 || pexil_out !== '0) begin
      miscompares++;
      $display("FAIL reset_async: got v=%b d=%b a=%0d p=%h want all zero", out_valid, done, write_adrr, pexil_out);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    got_n = 0; adr_bad = 0; done_cyc = -1;
    tick(); tick();
    vectors++;
    if (out_valid !== 1'b0 || done !== 1'b0 || got_n != 0) begin
      miscompares++;
      $display("FAIL reset_idle: got v=%b d=%b n=%0d want 0 0 0", out_valid, done, got_n);
    end
  endtask

  task automatic test_constant();
    for (int i = 0; i < N; i++) frame[i] = 24'h808080;
    run_frame(1'b0, N);
    check_count("const");
    for (int k = 0; k < N; k++) begin
      vectors++;
      if (got_pix[k] !== 24'h808080) begin
        miscompares++;
        $display("FAIL const_pix[%0d]: got %h want 808080", k, got_pix[k]);
      end
    end
    vectors++;
    if (got_cyc[0] != drv_cyc[W+1] + 2) begin
      miscompares++;
      $display("FAIL first_out_latency: got cycle %0d want %0d", got_cyc[0], drv_cyc[W+1] + 2);
    end
    vectors++;
    if (done_cyc != drv_cyc[N-1] + 33 || got_cyc[N-1] != done_cyc) begin
      miscompares++;
      $display("FAIL done_latency: got done %0d last out %0d want %0d", done_cyc, got_cyc[N-1], drv_cyc[N-1] + 33);
    end
    tick(); tick(); tick();
    vectors++;
    if (done !== 1'b1 || out_valid !== 1'b0 || write_adrr !== AW'(N-1)) begin
      miscompares++;
      $display("FAIL done_hold: got d=%b v=%b a=%0d want 1 0 %0d", done, out_valid, write_adrr, N-1);
    end
    start = 1'b0;
    tick();
    vectors++;
    if (done !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL done_clear: got d=%b v=%b want 0 0", done, out_valid);
    end
    tick();
  endtask

  task automatic test_impulse();
    int          idx  [6];
    logic [23:0] want [6];
    idx = '{310, 311, 341, 372, 280, 279};
    want = '{24'h400000, 24'h200000, 24'h100000, 24'h000000, 24'h200000, 24'h100000};
    for (int i = 0; i < N; i++) frame[i] = '0;
    frame[10*W + 10] = 24'hFF0000;
    run_frame(1'b0, N);
    check_count("impulse");
    for (int j = 0; j < 6; j++) begin
      vectors++;
      if (got_pix[idx[j]] !== want[j]) begin
        miscompares++;
        $display("FAIL impulse_pix[%0d]: got %h want %h", idx[j], got_pix[idx[j]], want[j]);
      end
    end
    stop_frame();
  endtask

  task automatic test_ramp();
    for (int i = 0; i < N; i++) frame[i] = 24'(i);
    run_frame(1'b0, N);
    check_count("ramp");
    for (int k = 0; k < N; k++) begin
      if (k / W == 0 || k / W == H-1 || k % W == 0 || k % W == W-1) begin
        vectors++;
        if (got_pix[k] !== 24'(k)) begin
          miscompares++;
          $display("FAIL ramp_border[%0d]: got %h want %h", k, got_pix[k], 24'(k));
        end
      end else begin
        vectors++;
        if (got_pix[k] !== gold(k)) begin
          miscompares++;
          $display("FAIL ramp_inner[%0d]: got %h want %h", k, got_pix[k], gold(k));
        end
      end
    end
    stop_frame();
  endtask

  task automatic test_gaps();
    for (int i = 0; i < N; i++) frame[i] = 24'($urandom);
    run_frame(1'b0, N);
    check_count("nogap");
    for (int k = 0; k < N; k++) begin
      ref_pix[k] = got_pix[k];
      vectors++;
      if (got_pix[k] !== gold(k)) begin
        miscompares++;
        $display("FAIL rand_pix[%0d]: got %h want %h", k, got_pix[k], gold(k));
      end
    end
    stop_frame();
    run_frame(1'b1, N);
    check_count("gaps");
    for (int k = 0; k < N; k++) begin
      vectors++;
      if (got_pix[k] !== ref_pix[k]) begin
        miscompares++;
        $display("FAIL gaps_pix[%0d]: got %h want %h", k, got_pix[k], ref_pix[k]);
      end
    end
    for (int k = 0; k < N - W - 1; k++) begin
      vectors++;
      if (got_cyc[k] != drv_cyc[k+W+1] + 2) begin
        miscompares++;
        $display("FAIL gaps_latency[%0d]: got cycle %0d want %0d", k, got_cyc[k], drv_cyc[k+W+1] + 2);
      end
    end
    stop_frame();
  endtask

  task automatic test_reset_mid();
    int n0;
    for (int i = 0; i < N; i++) frame[i] = 24'($urandom);
    run_frame(1'b0, 450);
    vectors++;
    if (got_n != 450 - W - 2) begin
      miscompares++;
      $display("FAIL midframe_outputs: got %0d want %0d", got_n, 450 - W - 2);
    end
    rst = 1'b1; start = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || done !== 1'b0 || write_adrr !== '0 || pexil_out !== '0) begin
      miscompares++;
      $display("FAIL midframe_reset: got v=%b d=%b a=%0d p=%h want all zero", out_valid, done, write_adrr, pexil_out);
    end
    tick(); tick();
    rst = 1'b0;
    n0 = got_n;
    repeat (5) tick();
    vectors++;
    if (got_n != n0) begin
      miscompares++;
      $display("FAIL post_reset_quiet: got %0d outputs want %0d", got_n, n0);
    end
    for (int i = 0; i < N; i++) frame[i] = 24'($urandom);
    run_frame(1'b0, N);
    check_count("restart");
    for (int k = 0; k < N; k++) begin
      vectors++;
      if (got_pix[k] !== gold(k)) begin
        miscompares++;
        $display("FAIL restart_pix[%0d]: got %h want %h", k, got_pix[k], gold(k));
      end
    end
    stop_frame();
  endtask

  initial begin
    test_reset();
    test_constant();
    test_impulse();
    test_ramp();
    test_gaps();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gauss_blur3x3.md
GAUSS_BLUR3X3 -- requirements
Module: gauss_blur3x3

Interface
REQ-001 Parameter WIDTH, default 30, image columns.
REQ-002 Parameter HEIGHT, default 30, image rows; frame size N = WIDTH*HEIGHT (900).
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  level enable; frame processing runs while high.
REQ-006 in_valid  input  1  pexil_in carries the next raster-order pixel.
REQ-007 pexil_in  input  24  RGB pixel from the upstream effects stage: [23:16] R, [15:8] G, [7:0] B.
REQ-008 pexil_out  output  24  filtered pixel, same channel layout.
REQ-009 out_valid  output  1  pexil_out and write_adrr valid this cycle.
REQ-010 write_adrr  output  clog2(N)  raster index of pexil_out into the new data memory.
REQ-011 done  output  1  frame complete.

Function
REQ-012 Input accepted on rising edge when state RUN and in_valid=1; raster order, index 0..N-1, counted internally by in_cnt.
REQ-013 Kernel per channel: corners x1, edge neighbours x2, centre x4; 12-bit sum; result = (sum+8)>>4, never exceeds 255.
REQ-014 Border pixels (row 0, row HEIGHT-1, col 0, col WIDTH-1) are output equal to their unfiltered input value.
REQ-015 Output index k is emitted, out_valid=1, exactly one cycle after input index k+WIDTH+1 is accepted.
REQ-016 in_valid=0 in RUN stalls the window, the line buffers and both counters; out_valid=0 during the following cycle.
REQ-017 States: IDLE, RUN, FLUSH, DONE.
REQ-018 IDLE->RUN when start=1; counters cleared on entry.
REQ-019 RUN->FLUSH on acceptance of input index N-1.
REQ-020 FLUSH: in_valid ignored; emits the remaining WIDTH+1 outputs, one per cycle, window fed with zeros (all remaining pixels are borders).
REQ-021 FLUSH->DONE on emission of index N-1; done=1 in that same cycle and held in DONE; write_adrr held at N-1.
REQ-022 DONE->IDLE when start=0; done clears.
REQ-023 start=0 in RUN or FLUSH aborts to IDLE: out_valid=0, partial frame discarded, counters cleared.
REQ-024 out_valid=0 in IDLE and DONE.

Reset
REQ-025 rst=1 forces state IDLE, in_cnt=0, out_cnt=0, pexil_out=0, out_valid=0, write_adrr=0, done=0 immediately, regardless of clk.
REQ-026 Line buffer and window contents need no reset; no output shall depend on them before they are refilled by the new frame.
REQ-027 Reset mid-frame: no further out_valid until a new start.

Structure
REQ-028 Shared package holds: state encoding, PIX_W=24, CH_W=8, default WIDTH/HEIGHT.
REQ-029 Sub-module line_buffer: WIDTH-deep 24-bit delay line with shift enable; instantiated twice (row-1, row-2).
REQ-030 3x3 window registers, kernel arithmetic and border mux in gauss_blur3x3; arithmetic is one combinational stage feeding the output register.

Verification
REQ-031 Constant frame 0x808080, in_valid held high -> all 900 outputs 0x808080; write_adrr 0..899 consecutive.
REQ-032 Impulse 0xFF0000 at (10,10), rest zero -> out(10,10)=0x400000, out(10,11)=0x200000, out(11,11)=0x100000, out(12,12)=0x000000.
REQ-033 Ramp frame pixel=index -> all row 0/29 and column 0/29 outputs equal input exactly.
REQ-034 Continuous in_valid -> first out_valid one cycle after input 31 accepted; done=1 exactly 32 cycles after input 899 accepted.
REQ-035 Random in_valid gaps -> output sequence identical to the gap-free run; never two outputs per accepted pixel.
REQ-036 rst pulse at input 450, then restart -> out_valid=0 immediately; the second frame matches the golden model bit-exactly.
